cic_comp_fir_mc: RTL and testbench
==================================

Name: cic_comp_fir_mc

Overview:
Next-generation CIC droop compensator for the interpolation chain of the sigma-delta DAC. It is a 3-tap symmetric FIR with transfer function H = -(a/2)(1 + z^-2) + (1 + a)z^-1, where a = ALPHA/8. It is generalised to CHANNELS time-multiplexed channels, each with its own history. It adds valid/ready flow control, runtime bypass, per-channel history clear and saturating output with a sticky overflow flag. It sits between the upsampler input stage and the CIC interpolator.

Parameters:
BITWIDTH, 32, signed sample width of in/out (legal 8..32)
ALPHA, 2, compensation numerator over 8 (legal 0..8; 0 gives a pure 1-sample delay)
CHANNELS, 2, number of time-multiplexed channels (legal 1..16)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
ena  input  1  global enable; when 0 the pipeline holds, in_ready=0, out_valid is held
in_valid  input  1  input sample valid
in_ready  output  1  block can accept a sample this cycle
in_data  input  BITWIDTH  signed input sample
in_chan  input  $clog2(CHANNELS) (min 1)  channel index of in_data
out_valid  output  1  output sample valid
out_ready  input  1  downstream accepts out_data
out_data  output  BITWIDTH  signed filtered sample
out_chan  output  $clog2(CHANNELS) (min 1)  channel index of out_data
bypass  input  1  when 1, out_data = in_data (sampled at accept), delayed by the same latency
clr  input  1  synchronous; zeroes all channel histories and the sat flag
sat  output  1  sticky; set when any output was clipped

Behaviour:
- Reset (rst=0, async): all histories = 0; both pipe stages invalid; out_valid=0; out_data=0; out_chan=0; sat=0.
- Accept: a sample is accepted when in_valid && in_ready && ena. An in_chan value >= CHANNELS is accepted and dropped: no output, no history change.
- History per channel: h1 (previous sample), h2 (two samples ago). On accept, x0 = in_data, x1 = h1[ch], x2 = h2[ch]; then h2[ch] <= h1[ch] and h1[ch] <= in_data. History updates even when bypass=1.
- Stage 1 (registered): acc = (16 + 2*ALPHA)*x1 - ALPHA*(x0 + x2), computed in BITWIDTH+6 signed bits. Multipliers are constants and may be implemented as shift-add. Stage 1 also captures in_chan, bypass and x0.
- Stage 2 (registered): y = acc >>> 4 (arithmetic shift, floor, no rounding). Saturate y to [-2^(BITWIDTH-1), 2^(BITWIDTH-1)-1]. Clipping sets sat. If bypass was captured, y = x0 unchanged and no clip check is made.
- DC gain is exactly 1.
- Latency: exactly 2 cycles from accept to out_valid when there is no backpressure. Throughput is 1 sample/clk.
- Flow control: stage 2 advances when !out_valid || out_ready. Stage 1 advances when stage 2 advances or stage 2 is empty. in_ready = ena && (stage 1 empty || stage 1 advances). out_data and out_chan stay stable while out_valid && !out_ready.
- clr: histories and sat clear next edge. In-flight samples still emerge. A sample accepted in the same cycle as clr uses zero history (clr takes priority over the history write, and that sample's value is not stored). If clr coincides with a clip, sat ends at 0.
- ena=0 mid-stream freezes all state, including histories; no sample is lost or duplicated.
- Reset mid-operation drops in-flight samples; out_valid falls asynchronously.

Decomposition:
- Package cic_comp_pkg: the ACC_GUARD=6 constant, the SHIFT=4 constant, a function sat_trunc(acc) returning the BITWIDTH result plus a clip bit, and chan_t sized by CHANNELS.
- One sub-module, cic_comp_hist: the per-channel h1/h2 register file with write enable and clr. The top holds the two pipe stages and the handshake.

Test Plan:
- Impulse (BITWIDTH=16, ALPHA=2, CHANNELS=1): in 1000,0,0,0 -> out -125, 1250, -125, 0; each out_valid exactly 2 clk after accept.
- DC: constant 1000 for 5 samples -> outputs -125, 1125, 1000, 1000, 1000.
- Saturation: -32768, -32768, 32767 -> third output -32768 (raw -40960); sat=1 and stays 1 until clr.
- Multi-channel interleave (CHANNELS=2): ch0 impulse 1000 and ch1 constant 500, alternating -> ch0 gives -125, 1250, -125; ch1 gives -63, 562, 500; out_chan matches; no cross-talk.
- Backpressure: out_ready=0 for 5 cycles with a continuous stream -> in_ready drops after 2 accepts; out_data held stable; after release, all samples appear in order with none lost.
- clr/bypass/reset: bypass=1 with in 7 -> out 7 two cycles later. clr then in 1000 -> out -125. Assert rst mid-stream -> out_valid=0 immediately; subsequent impulse reproduces -125, 1250, -125.

Source files
------------

// File: rtl/cic_comp_pkg.sv
// cic_comp_pkg
// Shared constants and helpers for the CIC droop compensator.
//   ACC_GUARD  : extra accumulator bits above the sample width
//   SHIFT      : right shift that removes the x16 coefficient scaling
//   chan_t     : channel index wide enough for the largest channel count
//   sat_trunc  : floor-shift an accumulator and clip it to a signed width
package cic_comp_pkg;

  localparam int ACC_GUARD    = 6;
  localparam int SHIFT        = 4;
  localparam int MAX_BITWIDTH = 32;
  localparam int ACC_MAX      = MAX_BITWIDTH + ACC_GUARD;
  localparam int MAX_CHANNELS = 16;

  typedef logic [$clog2(MAX_CHANNELS)-1:0] chan_t;

  typedef struct packed {
    logic [MAX_BITWIDTH-1:0] y;
    logic                    clip;
  } sat_res_t;

  // acc arrives sign-extended to ACC_MAX bits; y holds the low bw bits
  // of the clipped result (upper bits are don't-care for the caller).
  function automatic sat_res_t sat_trunc(input logic signed [ACC_MAX-1:0] acc,
                                         input int bw);
    logic signed [63:0] y_full;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    sat_res_t           r;
    y_full = 64'(acc);
    y_full = y_full >>> SHIFT;
    max_v  = (64'sd1 <<< (bw - 1)) - 64'sd1;
    min_v  = -max_v - 64'sd1;
    r.clip = 1'b0;
    r.y    = y_full[MAX_BITWIDTH-1:0];
    if (y_full > max_v) begin
      r.y    = max_v[MAX_BITWIDTH-1:0];
      r.clip = 1'b1;
    end else if (y_full < min_v) begin
      r.y    = min_v[MAX_BITWIDTH-1:0];
      r.clip = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cic_comp_fir_mc_hist.sv
// cic_comp_hist
// Per-channel sample history (h1 = previous sample, h2 = two samples ago).
//   clk, rst  : clock, async active-low reset
//   clr       : synchronous clear of every channel (wins over we)
//   we        : shift wdata into the history of channel chan
//   chan      : channel for both the read and the write
//   wdata     : new sample
//   h1_rd     : h1 of chan (0 when chan is out of range)
//   h2_rd     : h2 of chan (0 when chan is out of range)
module cic_comp_hist
  import cic_comp_pkg::*;
#(
  parameter int BITWIDTH = 32,
  parameter int CHANNELS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                we,
  input  chan_t               chan,
  input  logic [BITWIDTH-1:0] wdata,
  output logic [BITWIDTH-1:0] h1_rd,
  output logic [BITWIDTH-1:0] h2_rd
);

  logic [BITWIDTH-1:0] h1 [CHANNELS];
  logic [BITWIDTH-1:0] h2 [CHANNELS];

  always_comb begin
    h1_rd = '0;
    h2_rd = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (chan == chan_t'(i)) begin
        h1_rd = h1[i];
        h2_rd = h2[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        h1[i] <= '0;
        h2[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (clr) begin
          h1[i] <= '0;
          h2[i] <= '0;
        end else if (we && chan == chan_t'(i)) begin
          h2[i] <= h1[i];
          h1[i] <= wdata;
        end
      end
    end
  end

endmodule

// File: rtl/cic_comp_fir_mc.sv
// cic_comp_fir_mc
// Multi-channel 3-tap symmetric CIC droop compensator,
// H = -(a/2)(1 + z^-2) + (1 + a)z^-1 with a = ALPHA/8, two pipe stages,
// valid/ready handshake, bypass, history clear and saturating output.
//   clk, rst             : clock, async active-low reset
//   ena                  : global enable; 0 freezes every register
//   in_valid/in_ready    : input handshake
//   in_data, in_chan     : signed sample and its channel
//   out_valid/out_ready  : output handshake
//   out_data, out_chan   : filtered sample and its channel
//   bypass               : pass the accepted sample through unfiltered
//   clr                  : clear all histories and the sat flag
//   sat                  : sticky, set when an output was clipped
module cic_comp_fir_mc
  import cic_comp_pkg::*;
#(
  parameter  int BITWIDTH = 32,
  parameter  int ALPHA    = 2,
  parameter  int CHANNELS = 2,
  localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BITWIDTH-1:0] in_data,
  input  logic [CW-1:0]       in_chan,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BITWIDTH-1:0] out_data,
  output logic [CW-1:0]       out_chan,
  input  logic                bypass,
  input  logic                clr,
  output logic                sat
);

  localparam int AW = BITWIDTH + ACC_GUARD;
  // Coefficients scaled by 16: centre 16 + 2*ALPHA, outer taps ALPHA each.
  localparam logic signed [AW-1:0] C_MID  = AW'(16 + 2 * ALPHA);
  localparam logic signed [AW-1:0] C_SIDE = AW'(ALPHA);

  logic                 v1;
  logic                 byp1;
  logic [CW-1:0]        chan1;
  logic [BITWIDTH-1:0]  x0_1;
  logic signed [AW-1:0] acc1;

  logic                 adv2;
  logic                 accept;
  logic                 chan_ok;
  logic                 clr_eff;
  chan_t                wchan;
  logic [BITWIDTH-1:0]  h1_rd;
  logic [BITWIDTH-1:0]  h2_rd;
  logic signed [AW-1:0] x0e;
  logic signed [AW-1:0] x1e;
  logic signed [AW-1:0] x2e;
  logic signed [AW-1:0] acc_c;
  sat_res_t             sr;
  logic                 unused_sr;

  assign adv2     = ena && (!out_valid || out_ready);
  assign in_ready = ena && (!v1 || adv2);
  assign accept   = in_valid && in_ready;
  assign wchan    = chan_t'(in_chan);
  assign chan_ok  = int'(wchan) < CHANNELS;
  assign clr_eff  = ena && clr;

  cic_comp_hist #(
    .BITWIDTH (BITWIDTH),
    .CHANNELS (CHANNELS)
  ) u_hist (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_eff),
    .we    (accept && chan_ok),
    .chan  (wchan),
    .wdata (in_data),
    .h1_rd (h1_rd),
    .h2_rd (h2_rd)
  );

  // A sample arriving together with clr sees an already-cleared history.
  always_comb begin
    x0e = AW'($signed(in_data));
    x1e = clr_eff ? '0 : AW'($signed(h1_rd));
    x2e = clr_eff ? '0 : AW'($signed(h2_rd));
    acc_c = C_MID * x1e - C_SIDE * (x0e + x2e);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1    <= 1'b0;
      byp1  <= 1'b0;
      chan1 <= '0;
      x0_1  <= '0;
      acc1  <= '0;
    end else if (in_ready) begin
      v1 <= accept && chan_ok;
      if (accept) begin
        byp1  <= bypass;
        chan1 <= in_chan;
        x0_1  <= in_data;
        acc1  <= acc_c;
      end
    end
  end

  assign sr        = sat_trunc(ACC_MAX'(acc1), BITWIDTH);
  assign unused_sr = ^sr.y;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
    end else if (adv2) begin
      out_valid <= v1;
      if (v1) begin
        out_chan <= chan1;
        out_data <= byp1 ? x0_1 : sr.y[BITWIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat <= 1'b0;
    end else if (ena) begin
      if (clr)
        sat <= 1'b0;
      else if (adv2 && v1 && !byp1 && sr.clip)
        sat <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cic_comp_fir_mc.sv
// tb_cic_comp_fir_mc
// Directed tests for cic_comp_fir_mc with BITWIDTH=16, ALPHA=2, CHANNELS=3
// (channel 3 is a legal encoding but an out-of-range channel).
module tb_cic_comp_fir_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [1:0]  in_chan;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [1:0]  out_chan;
  logic        bypass;
  logic        clr;
  logic        sat;

  int checks = 0;
  int errors = 0;

  logic [17:0] mon_q [$];

  cic_comp_fir_mc #(
    .BITWIDTH (16),
    .ALPHA    (2),
    .CHANNELS (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_chan   (in_chan),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .bypass    (bypass),
    .clr       (clr),
    .sat       (sat)
  );

  always #5 clk = ~clk;

  // Records every completed output transfer (taken at the following edge).
  always @(negedge clk) begin
    if (rst && out_valid && out_ready && ena)
      mon_q.push_back({out_chan, out_data});
  end

  task automatic drive(input logic v, input logic [15:0] d, input logic [1:0] c);
    @(posedge clk);
    #1;
    in_valid = v;
    in_data  = d;
    in_chan  = c;
  endtask

  task automatic clear_hist();
    drive(1'b0, 16'd0, 2'd0);
    clr = 1'b1;
    drive(1'b0, 16'd0, 2'd0);
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'd0 || out_chan !== 2'd0 || sat !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b d=%0d c=%0d s=%b want 0 0 0 0",
               out_valid, out_data, out_chan, sat);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_impulse();
    logic signed [15:0] xin [4];
    logic signed [15:0] ey  [4];
    xin = '{16'sd1000, 16'sd0, 16'sd0, 16'sd0};
    ey  = '{-16'sd125, 16'sd1250, -16'sd125, 16'sd0};
    for (int n = 0; n < 6; n++) begin
      if (n < 4) drive(1'b1, xin[n], 2'd0);
      else       drive(1'b0, 16'd0, 2'd0);
      @(negedge clk);
      checks++;
      if (out_valid !== (n >= 2)) begin
        errors++;
        $display("FAIL impulse_valid[%0d] got %b want %b", n, out_valid, (n >= 2));
      end
      if (n >= 2) begin
        checks++;
        if (out_data !== ey[n-2]) begin
          errors++;
          $display("FAIL impulse_data[%0d] got %0d want %0d", n - 2, $signed(out_data), ey[n-2]);
        end
      end
    end
  endtask

  task automatic test_dc();
    logic signed [15:0] ey [5];
    ey = '{-16'sd125, 16'sd1125, 16'sd1000, 16'sd1000, 16'sd1000};
    clear_hist();
    for (int n = 0; n < 7; n++) begin
      if (n < 5) drive(1'b1, 16'd1000, 2'd0);
      else       drive(1'b0, 16'd0, 2'd0);
      @(negedge clk);
      if (n >= 2) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== ey[n-2]) begin
          errors++;
          $display("FAIL dc[%0d] got v=%b d=%0d want v=1 d=%0d", n - 2, out_valid,
                   $signed(out_data), ey[n-2]);
        end
      end
    end
  endtask

  task automatic test_multichan();
    logic signed [15:0] xs [6];
    logic [1:0]         cs [6];
    logic signed [15:0] ey [6];
    xs = '{16'sd1000, 16'sd500, 16'sd0, 16'sd500, 16'sd0, 16'sd500};
    cs = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1};
    ey = '{-16'sd125, -16'sd63, 16'sd1250, 16'sd562, -16'sd125, 16'sd500};
    clear_hist();
    for (int n = 0; n < 8; n++) begin
      if (n < 6) drive(1'b1, xs[n], cs[n]);
      else       drive(1'b0, 16'd0, 2'd0);
      @(negedge clk);
      if (n >= 2) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== ey[n-2] || out_chan !== cs[n-2]) begin
          errors++;
          $display("FAIL multichan[%0d] got v=%b d=%0d c=%0d want v=1 d=%0d c=%0d", n - 2,
                   out_valid, $signed(out_data), out_chan, ey[n-2], cs[n-2]);
        end
      end
    end
  endtask

  task automatic test_saturation();
    logic signed [15:0] xs [3];
    logic signed [15:0] ey [3];
    xs = '{-16'sd32768, -16'sd32768, 16'sd32767};
    ey = '{16'sd4096, -16'sd32768, -16'sd32768};
    clear_hist();
    for (int n = 0; n < 5; n++) begin
      if (n < 3) drive(1'b1, xs[n], 2'd0);
      else       drive(1'b0, 16'd0, 2'd0);
      @(negedge clk);
      if (n >= 2) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== ey[n-2]) begin
          errors++;
          $display("FAIL sat_data[%0d] got v=%b d=%0d want v=1 d=%0d", n - 2, out_valid,
                   $signed(out_data), ey[n-2]);
        end
      end
      if (n == 2 || n == 3) begin
        checks++;
        if (sat !== (n == 3)) begin
          errors++;
          $display("FAIL sat_flag[%0d] got %b want %b", n, sat, (n == 3));
        end
      end
    end
    repeat (3) drive(1'b0, 16'd0, 2'd0);
    @(negedge clk);
    checks++;
    if (sat !== 1'b1) begin
      errors++;
      $display("FAIL sat_sticky got %b want 1", sat);
    end
    clear_hist();
    @(negedge clk);
    checks++;
    if (sat !== 1'b0) begin
      errors++;
      $display("FAIL sat_clear got %b want 0", sat);
    end
    // clr lands on the same edge that registers a clipped output
    drive(1'b1, 16'h8000, 2'd0);
    drive(1'b1, 16'h8000, 2'd0);
    drive(1'b0, 16'd0, 2'd0);
    clr = 1'b1;
    drive(1'b0, 16'd0, 2'd0);
    clr = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h8000 || sat !== 1'b0) begin
      errors++;
      $display("FAIL sat_clr_coincide got v=%b d=%0d s=%b want v=1 d=-32768 s=0",
               out_valid, $signed(out_data), sat);
    end
    drive(1'b0, 16'd0, 2'd0);
    drive(1'b0, 16'd0, 2'd0);
  endtask

  task automatic test_bad_chan();
    logic signed [15:0] xs [4];
    logic [1:0]         cs [4];
    logic               ev [6];
    logic signed [15:0] ey [6];
    xs = '{16'sd1000, 16'sd9999, 16'sd0, 16'sd0};
    cs = '{2'd0, 2'd3, 2'd0, 2'd0};
    ev = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    ey = '{16'sd0, 16'sd0, -16'sd125, 16'sd0, 16'sd1250, -16'sd125};
    clear_hist();
    for (int n = 0; n < 6; n++) begin
      if (n < 4) drive(1'b1, xs[n], cs[n]);
      else       drive(1'b0, 16'd0, 2'd0);
      @(negedge clk);
      if (n >= 2) begin
        checks++;
        if (out_valid !== ev[n] || (ev[n] && out_data !== ey[n])) begin
          errors++;
          $display("FAIL bad_chan[%0d] got v=%b d=%0d want v=%b d=%0d", n, out_valid,
                   $signed(out_data), ev[n], ey[n]);
        end
      end
    end
  endtask

  task automatic test_bypass_clr();
    logic signed [15:0] ey [5];
    ey = '{16'sd7, -16'sd125, 16'sd0, 16'sd1000, 16'sd1250};
    clear_hist();
    for (int n = 0; n < 7; n++) begin
      case (n)
        0: begin drive(1'b1, 16'd7, 2'd0);    bypass = 1'b1; end
        1: begin drive(1'b1, 16'd1000, 2'd0); bypass = 1'b0; clr = 1'b1; end
        2: begin drive(1'b1, 16'd0, 2'd0);    clr = 1'b0; end
        3: begin drive(1'b1, 16'd1000, 2'd0); bypass = 1'b1; end
        4: begin drive(1'b1, 16'd0, 2'd0);    bypass = 1'b0; end
        default: drive(1'b0, 16'd0, 2'd0);
      endcase
      @(negedge clk);
      if (n >= 2) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== ey[n-2]) begin
          errors++;
          $display("FAIL bypass_clr[%0d] got v=%b d=%0d want v=1 d=%0d", n - 2, out_valid,
                   $signed(out_data), ey[n-2]);
        end
      end
    end
  endtask

  task automatic test_enable();
    clear_hist();
    for (int n = 0; n < 7; n++) begin
      case (n)
        0: drive(1'b1, 16'd1000, 2'd0);
        1: begin drive(1'b1, 16'd0, 2'd0); ena = 1'b0; end
        2: drive(1'b1, 16'd0, 2'd0);
        3: begin drive(1'b1, 16'd0, 2'd0); ena = 1'b1; end
        4: drive(1'b1, 16'd0, 2'd0);
        default: drive(1'b0, 16'd0, 2'd0);
      endcase
      @(negedge clk);
      if (n == 1 || n == 2) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL ena_in_ready[%0d] got %b want 0", n, in_ready);
        end
      end
      if (n == 3) begin
        checks++;
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL ena_frozen got v=%b want 0", out_valid);
        end
      end
      if (n >= 4) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== ((n == 5) ? 16'sd1250 : -16'sd125)) begin
          errors++;
          $display("FAIL ena_data[%0d] got v=%b d=%0d want v=1 d=%0d", n, out_valid,
                   $signed(out_data), (n == 5) ? 1250 : -125);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic signed [15:0] xs [6];
    logic signed [15:0] ey [6];
    int k;
    int stall_acc;
    xs = '{16'sd100, 16'sd200, 16'sd300, 16'sd400, 16'sd500, 16'sd600};
    ey = '{-16'sd13, 16'sd100, 16'sd200, 16'sd300, 16'sd400, 16'sd500};
    k = 0;
    stall_acc = 0;
    clear_hist();
    mon_q.delete();
    for (int cyc = 0; cyc < 60 && k < 6; cyc++) begin
      drive(1'b1, xs[k], 2'd0);
      out_ready = (cyc >= 5);
      @(negedge clk);
      if (cyc >= 2 && cyc < 5) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== ey[0]) begin
          errors++;
          $display("FAIL bp_hold[%0d] got v=%b d=%0d want v=1 d=%0d", cyc, out_valid,
                   $signed(out_data), ey[0]);
        end
      end
      if (in_ready) begin
        k++;
        if (cyc < 5) stall_acc++;
      end
    end
    out_ready = 1'b1;
    repeat (5) drive(1'b0, 16'd0, 2'd0);
    checks++;
    if (k !== 6) begin
      errors++;
      $display("FAIL bp_timeout got %0d accepted want 6", k);
    end
    checks++;
    if (stall_acc !== 2) begin
      errors++;
      $display("FAIL bp_stall_accepts got %0d want 2", stall_acc);
    end
    checks++;
    if (mon_q.size() !== 6) begin
      errors++;
      $display("FAIL bp_count got %0d want 6", mon_q.size());
    end
    for (int i = 0; i < 6 && i < mon_q.size(); i++) begin
      checks++;
      if (mon_q[i] !== {2'd0, ey[i]}) begin
        errors++;
        $display("FAIL bp_order[%0d] got %0d want %0d", i, $signed(mon_q[i][15:0]), ey[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 16'd1000, 2'd0);
    drive(1'b1, 16'd0, 2'd0);
    drive(1'b0, 16'd0, 2'd0);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pre got v=%b want 1", out_valid);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'd0) begin
      errors++;
      $display("FAIL rst_mid_async got v=%b d=%0d want v=0 d=0", out_valid, $signed(out_data));
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    test_impulse();
  endtask

  initial begin
    rst       = 1'b0;
    ena       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_chan   = '0;
    out_ready = 1'b1;
    bypass    = 1'b0;
    clr       = 1'b0;
    test_reset();
    test_impulse();
    test_dc();
    test_multichan();
    test_saturation();
    test_bad_chan();
    test_bypass_clr();
    test_enable();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
